mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares the single MEMORY request port between two bus masters. Port 0 is for CORE; port 1 is for a secondary master such as a program loader or debug unit. It sits between the masters and MEMORY in the SoC top. Each transaction is sequenced as a fixed issue, wait and acknowledge cycle pattern, and completion is returned to the granted master only.

## Interface
Parameters:
- WIDTH, `` `WIDTH ``: data width.
- ADDR_WIDTH, `` `ADDR_WIDTH ``: address width.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  reset; **synchronous, active-low**.
- req0_i / req1_i  in  1  transaction request from master 0 / 1.
- we0_i / we1_i  in  1  1 = write, 0 = read.
- addr0_i / addr1_i  in  ADDR_WIDTH  address.
- wdata0_i / wdata1_i  in  WIDTH  write data.
- ack0_o / ack1_o  out  1  one-cycle completion pulse.
- rdata0_o / rdata1_o  out  WIDTH  read data, valid while ack is high.
- memread_o, memwrite_o  out  1  MEMORY strobes.
- memaddr_o  out  ADDR_WIDTH  MEMORY address.
- memwdata_o  out  WIDTH  MEMORY write data.
- memrdata_i  in  WIDTH  MEMORY read data, valid one cycle after the memread_o cycle.

## Operation
- States: IDLE → ISSUE → WAIT → DONE → IDLE.
- **IDLE**
  - If no request: stay.
  - Otherwise pick the winner, latch its we/addr/wdata and its owner index, then go to ISSUE.
- **ISSUE**
  - memread_o = !we_latched; memwrite_o = we_latched, for exactly one cycle.
  - memaddr_o and memwdata_o come from the latch.
- **WAIT**
  - Strobes are 0.
  - On the closing edge, for reads only: rdataN_o(owner) ← memrdata_i.
- **DONE**
  - ackN_o(owner) = 1. Requests are ignored this cycle.
  - Go to IDLE.
- Arbitration:
  - Single request: it wins.
  - Both requesting: the port not granted last wins (pointer `last`).
  - `last` updates on every grant.
- Writes leave rdataN_o unchanged. The non-owner's ack and rdata are never touched.
- Masters must hold req/we/addr/wdata stable until their ack, then drop req on the edge ending the ack cycle.
- A request dropped before grant is simply never serviced.
- memaddr_o and memwdata_o hold their last values outside ISSUE. Only the strobes qualify them.

## Timing
- Edge E0 samples req in IDLE.
- ISSUE cycle follows E0.
- Read data is captured at E2.
- Ack is high in the cycle after E2, i.e. 3 cycles from sampling.
- Throughput: one transaction per 4 cycles. Back-to-back requests alternate ports when both are held.
- Reset values (rst low at an edge):
  - state = IDLE.
  - memread_o, memwrite_o, ack0_o, ack1_o = 0.
  - memaddr_o, memwdata_o, rdata0_o, rdata1_o = 0.
  - `last` = 1, so port 0 wins the first tie.
- Reset mid-transaction: the transaction is abandoned, no ack is issued, and strobes drop at that edge.
- Reset has priority over all transitions.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- Macro: `MEM_ARB_RR_EN`.
- Defined: round-robin tie-break using `last`, as above.
- Undefined: fixed priority, port 0 always wins ties. `last` is not implemented, and port 1 is served only when req0_i is low in IDLE.

## Structure
- Shared defines file holds:
  - `` `WIDTH `` and `` `ADDR_WIDTH `` (already present).
  - State encoding localparams ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_DONE (2 bits).
- One sub-module, **arb_pick2**: combinational 2-way winner select from req0, req1 and `last`. Its round-robin/fixed behaviour is selected by `MEM_ARB_RR_EN`.
- The datapath latch and FSM stay in mem_arbiter.

## Test plan
- **Reset:** hold rst=0 for 3 cycles with req0_i=1 → all outputs 0, no strobe. Release → port 0 read proceeds normally.
- **Port 0 read:** req0_i=1, we0_i=0, addr0_i=0x10, memory returns 0xDEADBEEF → memread_o high for exactly 1 cycle with memaddr_o=0x10. ack0_o high 3 cycles after sampling, rdata0_o=0xDEADBEEF, ack1_o stays 0.
- **Port 1 write:** req1_i=1, we1_i=1, addr1_i=0x20, wdata1_i=0x12345678 → memwrite_o 1 cycle with those values. ack1_o pulses, rdata1_o unchanged.
- **Simultaneous requests held for 4 transactions:**
  - With `MEM_ARB_RR_EN`: grant order 0, 1, 0, 1.
  - Without it: order 0, 0, 0, 0.
- **Reset mid-transaction:** rst=0 during WAIT → no ack. Next IDLE re-arbitrates and the tie goes to port 0.
- **Early drop:** req1_i pulsed for 1 cycle while port 0 owns the bus → port 1 never serviced, ack1_o stays 0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
//==============================================================================
// Module : mem_arbiter_pkg
// Brief  : Shared widths, state encoding and types for the memory arbiter.
// Rev    : 1.0 - initial release
//==============================================================================
`ifndef WIDTH
`define WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif

package mem_arbiter_pkg;

  localparam logic [1:0] ARB_IDLE  = 2'd0;
  localparam logic [1:0] ARB_ISSUE = 2'd1;
  localparam logic [1:0] ARB_WAIT  = 2'd2;
  localparam logic [1:0] ARB_DONE  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = ARB_IDLE,
    ST_ISSUE = ARB_ISSUE,
    ST_WAIT  = ARB_WAIT,
    ST_DONE  = ARB_DONE
  } arb_state_t;

  // 0 selects master 0 (CORE), 1 selects master 1
  typedef logic port_sel_t;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
//==============================================================================
// Module : mem_arbiter_if
// Brief  : Both master request ports plus the shared MEMORY port.
// Rev    : 1.0 - initial release
//==============================================================================
interface mem_arbiter_if #(
  parameter int WIDTH      = `WIDTH,
  parameter int ADDR_WIDTH = `ADDR_WIDTH
);
  logic                  req0_i, req1_i;
  logic                  we0_i, we1_i;
  logic [ADDR_WIDTH-1:0] addr0_i, addr1_i;
  logic [WIDTH-1:0]      wdata0_i, wdata1_i;
  logic                  ack0_o, ack1_o;
  logic [WIDTH-1:0]      rdata0_o, rdata1_o;
  logic                  memread_o, memwrite_o;
  logic [ADDR_WIDTH-1:0] memaddr_o;
  logic [WIDTH-1:0]      memwdata_o;
  logic [WIDTH-1:0]      memrdata_i;

  modport slave (
    input  req0_i, req1_i, we0_i, we1_i, addr0_i, addr1_i, wdata0_i, wdata1_i,
    input  memrdata_i,
    output ack0_o, ack1_o, rdata0_o, rdata1_o,
    output memread_o, memwrite_o, memaddr_o, memwdata_o
  );

  modport master (
    output req0_i, req1_i, we0_i, we1_i, addr0_i, addr1_i, wdata0_i, wdata1_i,
    output memrdata_i,
    input  ack0_o, ack1_o, rdata0_o, rdata1_o,
    input  memread_o, memwrite_o, memaddr_o, memwdata_o
  );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter_arb_pick2.sv
`default_nettype none
//==============================================================================
// Module : arb_pick2
// Brief  : 2-way winner select. MEM_ARB_RR_EN: round-robin on ties via i_last;
//          otherwise fixed priority to port 0.
// Rev    : 1.0 - initial release
//==============================================================================
module arb_pick2
  import mem_arbiter_pkg::*;
(
  input  wire logic i_req0,
  input  wire logic i_req1,
`ifdef MEM_ARB_RR_EN
  input  wire logic i_last,
`endif
  output port_sel_t o_grant
);

`ifdef MEM_ARB_RR_EN
  // On a tie the port not granted last time wins
  assign o_grant = i_req1 & (~i_req0 | ~i_last);
`else
  assign o_grant = i_req1 & ~i_req0;
`endif

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
//==============================================================================
// Module : mem_arbiter
// Brief  : Shares the MEMORY port between two masters with a fixed
//          issue/wait/ack sequence. Tie-break selected by MEM_ARB_RR_EN.
// Rev    : 1.0 - initial release
//==============================================================================
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int WIDTH      = `WIDTH,
  parameter int ADDR_WIDTH = `ADDR_WIDTH
) (
  input  wire logic    clk,
  input  wire logic    rst,
  mem_arbiter_if.slave bus
);

  arb_state_t            r_state;
  port_sel_t             r_owner;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [WIDTH-1:0]      r_wdata;
  logic [WIDTH-1:0]      r_rdata0, r_rdata1;
  logic                  r_memread, r_memwrite;
  logic                  r_ack0, r_ack1;
`ifdef MEM_ARB_RR_EN
  logic                  r_last;
`endif

  port_sel_t             w_grant;
  logic                  w_sel_we;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [WIDTH-1:0]      w_sel_wdata;

  arb_pick2 u_pick (
    .i_req0  (bus.req0_i),
    .i_req1  (bus.req1_i),
`ifdef MEM_ARB_RR_EN
    .i_last  (r_last),
`endif
    .o_grant (w_grant)
  );

  assign w_sel_we    = w_grant ? bus.we1_i    : bus.we0_i;
  assign w_sel_addr  = w_grant ? bus.addr1_i  : bus.addr0_i;
  assign w_sel_wdata = w_grant ? bus.wdata1_i : bus.wdata0_i;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_owner    <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata0   <= '0;
      r_rdata1   <= '0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
`ifdef MEM_ARB_RR_EN
      r_last     <= 1'b1;
`endif
    end else begin
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.req0_i || bus.req1_i) begin
            // Latch the winner here so strobes are registered in ISSUE
            r_owner    <= w_grant;
            r_we       <= w_sel_we;
            r_addr     <= w_sel_addr;
            r_wdata    <= w_sel_wdata;
            r_memread  <= ~w_sel_we;
            r_memwrite <= w_sel_we;
`ifdef MEM_ARB_RR_EN
            r_last     <= w_grant;
`endif
            r_state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: r_state <= ST_WAIT;
        ST_WAIT: begin
          if (!r_we) begin
            if (r_owner) r_rdata1 <= bus.memrdata_i;
            else         r_rdata0 <= bus.memrdata_i;
          end
          if (r_owner) r_ack1 <= 1'b1;
          else         r_ack0 <= 1'b1;
          r_state <= ST_DONE;
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.memread_o  = r_memread;
  assign bus.memwrite_o = r_memwrite;
  assign bus.memaddr_o  = r_addr;
  assign bus.memwdata_o = r_wdata;
  assign bus.ack0_o     = r_ack0;
  assign bus.ack1_o     = r_ack1;
  assign bus.rdata0_o   = r_rdata0;
  assign bus.rdata1_o   = r_rdata1;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
//==============================================================================
// Module : tb_mem_arbiter
// Brief  : Directed scenarios plus randomized traffic against a timing model.
// Rev    : 1.0 - initial release
//==============================================================================
module tb_mem_arbiter;

  localparam int W  = 32;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst;
  logic mem_init;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.WIDTH(W), .ADDR_WIDTH(AW)) bus ();

  mem_arbiter #(.WIDTH(W), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [W-1:0] init_val(input logic [AW-1:0] a);
    if (a == 8'h10) return 32'hDEADBEEF;
    return 32'hC0DE0000 | ({24'h0, a} * 32'h0000_0101);
  endfunction

  // Memory device: read data valid only in the cycle after the read strobe
  logic [W-1:0] mem [256];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i[AW-1:0]);
    end else if (bus.memwrite_o) begin
      mem[bus.memaddr_o] <= bus.memwdata_o;
    end
    bus.memrdata_i <= bus.memread_o ? mem[bus.memaddr_o] : $urandom;
  end

  task automatic clear_inputs();
    bus.req0_i = 0; bus.we0_i = 0; bus.addr0_i = '0; bus.wdata0_i = '0;
    bus.req1_i = 0; bus.we1_i = 0; bus.addr1_i = '0; bus.wdata1_i = '0;
  endtask

  task automatic test_reset();
    int lat;
    @(negedge clk);
    rst = 0; mem_init = 1;
    bus.req0_i = 1; bus.we0_i = 0; bus.addr0_i = 8'h04;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      mem_init = 0;
      n_cmp++;
      if (bus.memread_o !== 0 || bus.memwrite_o !== 0 || bus.ack0_o !== 0 || bus.ack1_o !== 0 ||
          bus.memaddr_o !== 0 || bus.memwdata_o !== 0 || bus.rdata0_o !== 0 || bus.rdata1_o !== 0) begin
        n_bad++;
        $display("FAIL reset_outputs c%0d: rd=%b wr=%b ack0=%b ack1=%b addr=%h wd=%h rd0=%h rd1=%h, required all 0",
                 c, bus.memread_o, bus.memwrite_o, bus.ack0_o, bus.ack1_o, bus.memaddr_o,
                 bus.memwdata_o, bus.rdata0_o, bus.rdata1_o);
      end
    end
    rst = 1;
    lat = 0;
    for (int c = 1; c <= 10 && lat == 0; c++) begin
      @(negedge clk);
      if (bus.ack0_o) lat = c;
    end
    n_cmp++;
    if (lat != 3) begin n_bad++; $display("FAIL reset_release_latency: got %0d required 3", lat); end
    n_cmp++;
    if (bus.rdata0_o !== init_val(8'h04)) begin
      n_bad++; $display("FAIL reset_release_rdata: got %h required %h", bus.rdata0_o, init_val(8'h04));
    end
    bus.req0_i = 0;
    @(negedge clk);
  endtask

  task automatic test_port0_read();
    int nrd = 0, nwr = 0, rdc = 0, ackc = 0;
    bit a1 = 0;
    logic [AW-1:0] sa = '0;
    logic [W-1:0]  rd = '0;
    bus.req0_i = 1; bus.we0_i = 0; bus.addr0_i = 8'h10;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (bus.memread_o) begin nrd++; rdc = c; sa = bus.memaddr_o; end
      if (bus.memwrite_o) nwr++;
      if (bus.ack1_o) a1 = 1;
      if (bus.ack0_o) begin ackc = c; rd = bus.rdata0_o; bus.req0_i = 0; end
    end
    n_cmp++;
    if (nrd != 1 || rdc != 1 || nwr != 0) begin
      n_bad++; $display("FAIL p0_read_strobe: reads=%0d at c%0d writes=%0d, required 1 read at c1, 0 writes", nrd, rdc, nwr);
    end
    n_cmp++;
    if (sa !== 8'h10) begin n_bad++; $display("FAIL p0_read_addr: got %h required 10", sa); end
    n_cmp++;
    if (ackc != 3) begin n_bad++; $display("FAIL p0_read_ack_cycle: got %0d required 3", ackc); end
    n_cmp++;
    if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL p0_read_rdata: got %h required deadbeef", rd); end
    n_cmp++;
    if (a1) begin n_bad++; $display("FAIL p0_read_ack1: got 1 required 0"); end
  endtask

  task automatic test_port1_write();
    int nrd = 0, nwr = 0, wrc = 0, ackc = 0;
    bit a0 = 0;
    logic [AW-1:0] sa = '0;
    logic [W-1:0]  sw = '0, rd = '1;
    bus.req1_i = 1; bus.we1_i = 1; bus.addr1_i = 8'h20; bus.wdata1_i = 32'h12345678;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (bus.memwrite_o) begin nwr++; wrc = c; sa = bus.memaddr_o; sw = bus.memwdata_o; end
      if (bus.memread_o) nrd++;
      if (bus.ack0_o) a0 = 1;
      if (bus.ack1_o) begin ackc = c; rd = bus.rdata1_o; bus.req1_i = 0; end
    end
    n_cmp++;
    if (nwr != 1 || wrc != 1 || nrd != 0) begin
      n_bad++; $display("FAIL p1_write_strobe: writes=%0d at c%0d reads=%0d, required 1 write at c1, 0 reads", nwr, wrc, nrd);
    end
    n_cmp++;
    if (sa !== 8'h20 || sw !== 32'h12345678) begin
      n_bad++; $display("FAIL p1_write_bus: addr=%h data=%h required 20/12345678", sa, sw);
    end
    n_cmp++;
    if (ackc != 3) begin n_bad++; $display("FAIL p1_write_ack_cycle: got %0d required 3", ackc); end
    n_cmp++;
    if (rd !== 32'h0) begin n_bad++; $display("FAIL p1_write_rdata_kept: got %h required 0", rd); end
    n_cmp++;
    if (a0) begin n_bad++; $display("FAIL p1_write_ack0: got 1 required 0"); end
  endtask

  task automatic test_back_to_back();
    int order [4];
    int exp_order [4];
    int ng = 0, na = 0, k0 = 0, k1 = 0;
`ifdef MEM_ARB_RR_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{0, 0, 0, 0};
`endif
    order = '{-1, -1, -1, -1};
    @(negedge clk); rst = 0;
    @(negedge clk); rst = 1;
    bus.req0_i = 1; bus.we0_i = 0; bus.addr0_i = 8'h30;
    bus.req1_i = 1; bus.we1_i = 0; bus.addr1_i = 8'h40;
    for (int c = 0; c < 40 && na < 4; c++) begin
      @(negedge clk);
      if (bus.memread_o && ng < 4) begin order[ng] = (bus.memaddr_o >= 8'h40) ? 1 : 0; ng++; end
      if (bus.ack0_o || bus.ack1_o) begin
        na++;
        n_cmp++;
        if (bus.ack0_o && bus.rdata0_o !== init_val(bus.addr0_i)) begin
          n_bad++; $display("FAIL b2b_rdata0: got %h required %h", bus.rdata0_o, init_val(bus.addr0_i));
        end else if (bus.ack1_o && bus.rdata1_o !== init_val(bus.addr1_i)) begin
          n_bad++; $display("FAIL b2b_rdata1: got %h required %h", bus.rdata1_o, init_val(bus.addr1_i));
        end
        if (bus.ack0_o) begin k0++; bus.addr0_i = 8'h30 + 8'(k0); end
        if (bus.ack1_o) begin k1++; bus.addr1_i = 8'h40 + 8'(k1); end
        if (na == 4) begin bus.req0_i = 0; bus.req1_i = 0; end
      end
    end
    n_cmp++;
    if (na != 4) begin n_bad++; $display("FAIL b2b_ack_count: got %0d required 4", na); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (order[i] != exp_order[i]) begin
        n_bad++; $display("FAIL b2b_grant_%0d: got port %0d required port %0d", i, order[i], exp_order[i]);
      end
    end
    clear_inputs();
    @(negedge clk); @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit seen = 0, stray = 0;
    int scyc = 0;
    logic [AW-1:0] sa = '0;
    bus.req0_i = 1; bus.we0_i = 0; bus.addr0_i = 8'h50;
    for (int c = 1; c <= 10 && !seen; c++) begin
      @(negedge clk);
      if (bus.ack0_o) seen = 1;
    end
    bus.req0_i = 0;
    @(negedge clk);
    bus.req0_i = 1; bus.addr0_i = 8'h51;
    bus.req1_i = 1; bus.we1_i = 0; bus.addr1_i = 8'h61;
    @(negedge clk);
    n_cmp++;
    if (bus.memread_o !== 1'b1) begin n_bad++; $display("FAIL mid_issue: memread=%b required 1", bus.memread_o); end
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    n_cmp++;
    if (bus.ack0_o !== 0 || bus.ack1_o !== 0 || bus.memread_o !== 0 || bus.memwrite_o !== 0) begin
      n_bad++; $display("FAIL mid_reset_quiet: ack0=%b ack1=%b rd=%b wr=%b required 0",
                        bus.ack0_o, bus.ack1_o, bus.memread_o, bus.memwrite_o);
    end
    rst = 1;
    for (int c = 1; c <= 10 && scyc == 0; c++) begin
      @(negedge clk);
      if (bus.ack0_o || bus.ack1_o) stray = 1;
      if (bus.memread_o) begin scyc = c; sa = bus.memaddr_o; end
    end
    n_cmp++;
    if (scyc != 1 || sa !== 8'h51) begin
      n_bad++; $display("FAIL mid_regrant: cycle %0d addr %h, required cycle 1 addr 51", scyc, sa);
    end
    seen = 0;
    for (int c = 1; c <= 6 && !seen; c++) begin
      @(negedge clk);
      if (bus.ack1_o) stray = 1;
      if (bus.ack0_o) begin
        seen = 1;
        n_cmp++;
        if (bus.rdata0_o !== init_val(8'h51)) begin
          n_bad++; $display("FAIL mid_rdata0: got %h required %h", bus.rdata0_o, init_val(8'h51));
        end
        bus.req0_i = 0; bus.req1_i = 0;
      end
    end
    n_cmp++;
    if (!seen || stray) begin n_bad++; $display("FAIL mid_acks: ack0 seen=%b stray ack=%b, required 1/0", seen, stray); end
    clear_inputs();
    @(negedge clk);
  endtask

  task automatic test_early_drop();
    int nstb = 0;
    bit a0 = 0, a1 = 0;
    bus.req0_i = 1; bus.we0_i = 0; bus.addr0_i = 8'h70;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (bus.memread_o || bus.memwrite_o) nstb++;
      if (bus.ack1_o) a1 = 1;
      if (bus.ack0_o) begin a0 = 1; bus.req0_i = 0; end
      if (c == 1) begin bus.req1_i = 1; bus.we1_i = 0; bus.addr1_i = 8'h71; end
      if (c == 2) bus.req1_i = 0;
    end
    n_cmp++;
    if (nstb != 1 || !a0 || a1) begin
      n_bad++; $display("FAIL early_drop: strobes=%0d ack0=%b ack1=%b, required 1/1/0", nstb, a0, a1);
    end
    clear_inputs();
  endtask

  logic [W-1:0] ref_mem [256];

  task automatic test_random(input int n);
    bit            rq [2], rq_prev [2];
    logic          p_we [2];
    logic [AW-1:0] p_addr [2];
    logic [W-1:0]  p_wdata [2];
    logic [W-1:0]  exp_rd = '0, mrd0 = '0, mrd1 = '0;
    int  cyc = 0, grant_ok = 1, ack_cyc = -100, ack_port = 0, last_m = 1, win = 0;
    bit  ack_rd = 0, e_rd, e_wr, e_a0, e_a1, draining, sr;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i[AW-1:0]);
    for (int p = 0; p < 2; p++) begin
      rq[p] = 0; rq_prev[p] = 0; p_we[p] = 0; p_addr[p] = '0; p_wdata[p] = '0;
    end
    @(negedge clk); rst = 0; mem_init = 1; clear_inputs();
    @(negedge clk); rst = 1; mem_init = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      draining = (cyc >= n);
      // A grant is made on the first edge in IDLE that sees a request; the next
      // transaction may start four cycles after the previous strobe.
      sr = (cyc >= grant_ok) && (rq_prev[0] || rq_prev[1]);
      e_rd = 0; e_wr = 0;
      if (sr) begin
        if (rq_prev[0] && rq_prev[1]) begin
`ifdef MEM_ARB_RR_EN
          win = (last_m == 0) ? 1 : 0;
`else
          win = 0;
`endif
        end else begin
          win = rq_prev[1] ? 1 : 0;
        end
        last_m = win; grant_ok = cyc + 4; ack_cyc = cyc + 2; ack_port = win; ack_rd = !p_we[win];
        e_rd = !p_we[win]; e_wr = p_we[win];
        if (p_we[win]) ref_mem[p_addr[win]] = p_wdata[win];
        else           exp_rd = ref_mem[p_addr[win]];
      end
      n_cmp++;
      if (bus.memread_o !== e_rd || bus.memwrite_o !== e_wr) begin
        n_bad++; $display("FAIL rnd_strobe cyc %0d: rd=%b wr=%b required %b/%b", cyc, bus.memread_o, bus.memwrite_o, e_rd, e_wr);
      end
      if (sr) begin
        n_cmp++;
        if (bus.memaddr_o !== p_addr[win] || (e_wr && bus.memwdata_o !== p_wdata[win])) begin
          n_bad++; $display("FAIL rnd_issue cyc %0d port %0d: addr=%h wd=%h required %h/%h",
                            cyc, win, bus.memaddr_o, bus.memwdata_o, p_addr[win], p_wdata[win]);
        end
      end
      if (cyc == ack_cyc && ack_rd) begin
        if (ack_port == 1) mrd1 = exp_rd; else mrd0 = exp_rd;
      end
      e_a0 = (cyc == ack_cyc) && (ack_port == 0);
      e_a1 = (cyc == ack_cyc) && (ack_port == 1);
      n_cmp++;
      if (bus.ack0_o !== e_a0 || bus.ack1_o !== e_a1 || bus.rdata0_o !== mrd0 || bus.rdata1_o !== mrd1) begin
        n_bad++; $display("FAIL rnd_ack cyc %0d: ack=%b%b rd0=%h rd1=%h required %b%b %h %h",
                          cyc, bus.ack0_o, bus.ack1_o, bus.rdata0_o, bus.rdata1_o, e_a0, e_a1, mrd0, mrd1);
      end
      for (int p = 0; p < 2; p++) begin
        if (cyc == ack_cyc && ack_port == p) begin
          rq[p] = !draining && ($urandom_range(0, 3) != 0);
        end else if (!rq[p] && !draining && $urandom_range(0, 2) == 0) begin
          rq[p] = 1;
        end else begin
          continue;
        end
        if (rq[p]) begin
          p_we[p] = 1'($urandom_range(0, 1));
          p_addr[p] = AW'($urandom_range(0, 15));
          p_wdata[p] = $urandom;
        end
      end
      bus.req0_i = rq[0]; bus.we0_i = p_we[0]; bus.addr0_i = p_addr[0]; bus.wdata0_i = p_wdata[0];
      bus.req1_i = rq[1]; bus.we1_i = p_we[1]; bus.addr1_i = p_addr[1]; bus.wdata1_i = p_wdata[1];
      rq_prev = rq;
      if (draining && !rq[0] && !rq[1] && cyc > ack_cyc) break;
      if (cyc > n + 60) begin
        n_cmp++; n_bad++;
        $display("FAIL rnd_timeout: still busy at cycle %0d, required idle by %0d", cyc, n + 60);
        break;
      end
    end
    clear_inputs();
    @(negedge clk);
  endtask

  initial begin
    rst = 0;
    mem_init = 0;
    bus.memrdata_i = '0;
    clear_inputs();
    test_reset();
    test_port0_read();
    test_port1_write();
    test_back_to_back();
    test_reset_mid();
    test_early_drop();
    test_random(800);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
